// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage:
//   PC_W       - program counter / instruction width (32)
//   NOP_INST   - encoding placed in IF/ID when it holds no live instruction
//   fetch_state_e - fetch FSM state encoding (IDLE, REQ, HOLD)
//   pc_align / pc_incr - PC helpers (word alignment, modulo-2^32 increment)
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int unsigned    PC_W     = 32;
    localparam logic [PC_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    // Instructions are word aligned, so the two low PC bits are always zero.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
        return pc_align(pc + 32'd4);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with three operations: flush (highest priority,
// inserts NOP with valid=0, pc kept), load (captures pc/inst, valid=1) and
// hold (default).
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   load_i, flush_i    - register operation select
//   pc_i, inst_i       - values captured on load
//   pc_o, inst_o       - register contents
//   valid_o            - register holds a live instruction
// -----------------------------------------------------------------------------
module if_id_reg
    import if_fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] inst_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] inst_o,
    output logic            valid_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] inst_q;
    logic            valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: PC register, fetch FSM (IDLE/REQ/HOLD), a one-entry
// hold buffer for instructions returned while the pipeline is stalled, and
// the IF/ID register (if_id_reg).
// Optional feature: define FETCH_PERF_CNT_EN to add fetch_cnt/squash_cnt.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   pc_en_if            - 0 = stall (hold PC and IF/ID)
//   fd_flush            - redirect to branch_target_id and squash IF/ID
//   branch_target_id    - redirect address
//   imem_req/imem_addr  - fetch request and address (= PC)
//   imem_ack/imem_rdata - fetch completion and returned instruction
//   pc_ID/inst_ID/valid_ID - IF/ID register contents
//   fetch_cnt/squash_cnt   - (FETCH_PERF_CNT_EN only) accepted fetches, flushes
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     squash_cnt,
`endif
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_en_if,
    input  logic            fd_flush,
    input  logic [PC_W-1:0] branch_target_id,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] pc_ID,
    output logic [PC_W-1:0] inst_ID,
    output logic            valid_ID
);

    fetch_state_e    state_q;
    logic            req_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] hold_q;
    logic            drop_q;     // an ack for a request abandoned by a flush is still due

    logic            ifid_load;
    logic            ifid_flush;
    logic [PC_W-1:0] ifid_inst;

    // IF/ID control. When the pipeline advances but no instruction arrives,
    // a bubble is inserted so ID never sees the same instruction twice.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_inst  = imem_rdata;
        if (fd_flush) begin
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (pc_en_if) begin
                        if (imem_ack && !drop_q) ifid_load  = 1'b1;
                        else                     ifid_flush = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (pc_en_if) begin
                        ifid_load = 1'b1;
                        ifid_inst = hold_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            pc_q    <= pc_align(RESET_PC);
            hold_q  <= '0;
            drop_q  <= 1'b0;
        end else if (fd_flush) begin
            pc_q    <= pc_align(branch_target_id);
            hold_q  <= '0;
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            // Only an outstanding, not-yet-acked request leaves a stale ack behind.
            drop_q  <= (state_q == ST_REQ) && !imem_ack;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        if (drop_q) begin
                            // stale data; the request is reissued at the current PC
                            drop_q <= 1'b0;
                        end else if (pc_en_if) begin
                            pc_q <= pc_incr(pc_q);
                        end else begin
                            hold_q  <= imem_rdata;
                            state_q <= ST_HOLD;
                            req_q   <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (pc_en_if) begin
                        pc_q    <= pc_incr(pc_q);
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (pc_q),
        .inst_i  (ifid_inst),
        .pc_o    (pc_ID),
        .inst_o  (inst_ID),
        .valid_o (valid_ID)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] squash_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (ifid_load) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (fd_flush)  squash_cnt_q <= squash_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule
